historical_bit_packer: RTL
==========================

// Module: historical_bit_packer
// PURPOSE
//  Serial-to-parallel packer upstream of the HistoricalBit register bank.
//  Collects 1-bit pixel samples from the drawing canvas into NrOfBits-wide row words,
//  then drives D, Tick and a row address so the addressed register loads the word.
//  Counts NrOfWords rows per frame and flags frame completion to the recogniser.
// PARAMETERS
//  NrOfBits   28  bits per row word (matches register width)
//  NrOfWords  28  row words per frame
//  AddrBits   5   width of WordAddr; 2^AddrBits >= NrOfWords
// PORTS
//  Clock      in   1         system clock, all state on rising edge
//  Reset      in   1         asynchronous, active-low reset
//  Clear      in   1         synchronous frame restart
//  Hold       in   1         1 = stall intake (BitReady forced 0)
//  BitIn      in   1         pixel sample
//  BitValid   in   1         BitIn valid this cycle
//  BitReady   out  1         packer accepts BitIn this cycle
//  WordOut    out  NrOfBits  completed row word (to register D)
//  WordTick   out  1         one-cycle load strobe (to register Tick)
//  WordAddr   out  AddrBits  row index of WordOut (register select)
//  BitCount   out  clog2(NrOfBits+1)  bits held in current partial word
//  FrameDone  out  1         level, all NrOfWords rows emitted
// BEHAVIOUR
//  Reset (Reset=0, async): state FILL; shift reg, BitCount, row counter, WordOut,
//   WordAddr = 0; WordTick=0, FrameDone=0. Released synchronously by design context.
//  Accept: transfer when BitValid & BitReady; BitReady = (state==FILL) & ~Hold & ~Clear.
//  Packing MSB-first: 1st accepted bit of a word ends at WordOut[NrOfBits-1], last at [0].
//  States: FILL (accepting), DONE (frame complete, BitReady=0).
//  FILL: each transfer shifts BitIn in, BitCount+1. On the transfer that makes
//   BitCount==NrOfBits: next cycle WordOut=word, WordAddr=row, WordTick=1 (latency 1),
//   BitCount->0, row+1. The next word's bit is accepted in that tick cycle (no bubble).
//  WordTick high exactly 1 cycle per word; WordOut/WordAddr hold until next word.
//  Last row (row==NrOfWords-1) completing: tick as above, state->DONE same edge,
//   FrameDone=1 with the tick cycle and stays 1 until Clear.
//  DONE: BitValid ignored, no shifts, no ticks.
//  Clear=1 (any state, priority over transfer): next edge -> FILL, BitCount=0, row=0,
//   FrameDone=0, WordTick=0; partial word discarded; WordOut/WordAddr keep last value.
//  Clear coincident with a word-completing bit: bit not accepted, no tick.
//  Hold mid-word: partial word and BitCount retained; resumes on Hold=0.
//  Pending tick (word completed previous edge) is still issued even if Hold or
//   Clear asserts in the tick cycle.
//  Reset mid-frame: all progress lost, outputs to reset values immediately.
//  Row counter width AddrBits; never exceeds NrOfWords-1, no wrap within a frame.
// TESTING
//  1 Reset=0 mid-stream -> all outputs 0 same cycle; after release BitReady=1, BitCount=0.
//  2 Stream 28 bits 1,0,1,0... continuous -> 1 cycle after 28th, WordTick=1,
//    WordOut=28'hAAAAAAA, WordAddr=0; 29th bit accepted during tick.
//  3 Full frame 784 bits, BitValid random 50% -> 28 ticks, WordAddr 0..27 in order,
//    FrameDone=1 on 28th tick cycle, BitReady=0 after; extra BitValid ignored.
//  4 Hold=1 after 10 bits for 5 cycles -> BitReady=0, BitCount stays 10; word content
//    unchanged vs. no-hold reference after completion.
//  5 Clear on the 28th bit of row 3 -> no tick, BitCount=0, next word tagged WordAddr=0.
//  6 Clear while DONE -> FrameDone=0 next cycle, BitReady=1, new frame packs from row 0.

Source files
------------

// File: rtl/historical_bit_packer_if.sv
// Bit intake and row-word output bundle of the historical bit packer.
interface historical_bit_packer_if #(
  parameter int NrOfBits  = 28,
  parameter int AddrBits  = 5,
  parameter int CntBits   = $clog2(NrOfBits + 1)
);
  logic                Clear;
  logic                Hold;
  logic                BitIn;
  logic                BitValid;
  logic                BitReady;
  logic [NrOfBits-1:0] WordOut;
  logic                WordTick;
  logic [AddrBits-1:0] WordAddr;
  logic [CntBits-1:0]  BitCount;
  logic                FrameDone;

  modport master (
    output Clear, Hold, BitIn, BitValid,
    input  BitReady, WordOut, WordTick,
    input  WordAddr, BitCount, FrameDone
  );

  modport slave (
    input  Clear, Hold, BitIn, BitValid,
    output BitReady, WordOut, WordTick,
    output WordAddr, BitCount, FrameDone
  );
endinterface

// File: rtl/historical_bit_packer.sv
// Packs canvas pixel bits MSB-first into row words and
// strobes them into the HistoricalBit register bank.
module historical_bit_packer #(
  parameter int NrOfBits  = 28,
  parameter int NrOfWords = 28,
  parameter int AddrBits  = 5,
  parameter int CntBits   = $clog2(NrOfBits + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  historical_bit_packer_if.slave bus
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  localparam logic [CntBits-1:0]  LastBit =
    CntBits'(NrOfBits - 1);
  localparam logic [AddrBits-1:0] LastRow =
    AddrBits'(NrOfWords - 1);

  logic [0:0]          state_q, state_d;
  logic [NrOfBits-1:0] shift_q, shift_d;
  logic [CntBits-1:0]  cnt_q, cnt_d;
  logic [AddrBits-1:0] row_q, row_d;
  logic [NrOfBits-1:0] word_q, word_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  logic                ready;
  logic                xfer;
  logic [NrOfBits-1:0] shifted;

  // Ready is gated by reset so every output reads 0 while held in reset.
  assign ready = rst_ni & (state_q == FILL) &
                 ~bus.Hold & ~bus.Clear;
  assign xfer    = bus.BitValid & ready;
  assign shifted = {shift_q[NrOfBits-2:0], bus.BitIn};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    word_d  = word_q;
    addr_d  = addr_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    unique case (1'b1)
      bus.Clear: begin
        state_d = FILL;
        cnt_d   = '0;
        row_d   = '0;
        done_d  = 1'b0;
      end
      xfer: begin
        shift_d = shifted;
        if (cnt_q == LastBit) begin
          cnt_d  = '0;
          word_d = shifted;
          addr_d = row_q;
          tick_d = 1'b1;
          if (row_q == LastRow) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + AddrBits'(1);
          end
        end else begin
          cnt_d = cnt_q + CntBits'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      shift_q <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.BitReady  = ready;
  assign bus.WordOut   = word_q;
  assign bus.WordTick  = tick_q;
  assign bus.WordAddr  = addr_q;
  assign bus.BitCount  = cnt_q;
  assign bus.FrameDone = done_q;

endmodule
